// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle FSM and the datapath it steers.
interface multicycle_control_fsm_if #(
  parameter int unsigned OP_WIDTH    = 6,
  parameter int unsigned STATE_WIDTH = 4
) ();

  logic [OP_WIDTH-1:0]    Opcode;
  logic                   MemReady;
  logic                   PCWrite;
  logic                   PCWriteCond;
  logic                   IorD;
  logic                   MemRead;
  logic                   MemWrite;
  logic                   IRWrite;
  logic                   MemtoReg;
  logic                   RegDst;
  logic                   RegWrite;
  logic                   ALUSrcA;
  logic [1:0]             ALUSrcB;
  logic [1:0]             ALUOp;
  logic [1:0]             PCSource;
  logic                   InvalidOp;
  logic [STATE_WIDTH-1:0] State;

  // Datapath side: supplies opcode and memory handshake, consumes controls.
  modport master (
    output Opcode, MemReady,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
    input  RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, InvalidOp, State
  );

  // Controller side.
  modport slave (
    input  Opcode, MemReady,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
    output RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, InvalidOp, State
  );

endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing
// with a memory-ready stall handshake and unsupported-opcode flagging.
module multicycle_control_fsm #(
  parameter int unsigned OP_WIDTH    = 6,
  parameter int unsigned STATE_WIDTH = 4
) (
  input logic                     clock,
  input logic                     reset_n,
  multicycle_control_fsm_if.slave bus
);

  localparam logic [OP_WIDTH-1:0] OpRtype = OP_WIDTH'(6'b000000);
  localparam logic [OP_WIDTH-1:0] OpLw    = OP_WIDTH'(6'b100011);
  localparam logic [OP_WIDTH-1:0] OpSw    = OP_WIDTH'(6'b101011);
  localparam logic [OP_WIDTH-1:0] OpBeq   = OP_WIDTH'(6'b000100);
  localparam logic [OP_WIDTH-1:0] OpJ     = OP_WIDTH'(6'b000010);
  localparam logic [OP_WIDTH-1:0] OpAddi  = OP_WIDTH'(6'b001000);

  typedef enum logic [STATE_WIDTH-1:0] {
    StFetch    = STATE_WIDTH'(0),
    StDecode   = STATE_WIDTH'(1),
    StMemAdr   = STATE_WIDTH'(2),
    StMemRead  = STATE_WIDTH'(3),
    StMemWb    = STATE_WIDTH'(4),
    StMemWrite = STATE_WIDTH'(5),
    StRtypeEx  = STATE_WIDTH'(6),
    StRtypeWb  = STATE_WIDTH'(7),
    StBeqEx    = STATE_WIDTH'(8),
    StJEx      = STATE_WIDTH'(9),
    StAddiEx   = STATE_WIDTH'(10),
    StAddiWb   = STATE_WIDTH'(11)
  } state_t;

  state_t state_q, state_d;

  // State register; reset forces FETCH immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode; every control defaults low.
  always_comb begin
    state_d         = StFetch;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = 2'b00;
    bus.PCSource    = 2'b00;
    bus.InvalidOp   = 1'b0;
    bus.State       = state_q;

    case (state_q)
      StFetch: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        // IR and PC+4 commit only in the cycle memory delivers the word.
        bus.IRWrite = bus.MemReady;
        bus.PCWrite = bus.MemReady;
        state_d     = bus.MemReady ? StDecode : StFetch;
      end
      StDecode: begin
        // Precompute the branch target while the opcode is decoded.
        bus.ALUSrcB = 2'b11;
        case (bus.Opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StRtypeEx;
          OpBeq:      state_d = StBeqEx;
          OpJ:        state_d = StJEx;
          OpAddi:     state_d = StAddiEx;
          default: begin
            bus.InvalidOp = 1'b1;
            state_d       = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = (bus.Opcode == OpSw) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        state_d     = bus.MemReady ? StMemWb : StMemRead;
      end
      StMemWb: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
        state_d      = StFetch;
      end
      StMemWrite: begin
        // Level strobe: held for every stall cycle.
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        state_d      = bus.MemReady ? StFetch : StMemWrite;
      end
      StRtypeEx: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
        state_d     = StRtypeWb;
      end
      StRtypeWb: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
        state_d      = StFetch;
      end
      StBeqEx: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
        state_d         = StFetch;
      end
      StJEx: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
        state_d      = StFetch;
      end
      StAddiEx: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = StAddiWb;
      end
      StAddiWb: begin
        bus.RegWrite = 1'b1;
        state_d      = StFetch;
      end
      // Unused codes drive nothing and recover to FETCH.
      default: state_d = StFetch;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed instruction scenarios plus randomized
// opcode/MemReady traffic, all checked each cycle against an instruction-route model.
module tb_multicycle_control_fsm;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpAddi = 6'b001000;

  // Bit positions in the packed control vector.
  localparam int BPcWrite = 20, BPcWriteCond = 19, BMemWrite = 16, BIrWrite = 15;
  localparam int BMemtoReg = 14, BRegDst = 13, BRegWrite = 12, BInvalid = 4;

  logic clock;
  logic reset_n;

  multicycle_control_fsm_if #(.OP_WIDTH(6), .STATE_WIDTH(4)) bus ();

  multicycle_control_fsm #(.OP_WIDTH(6), .STATE_WIDTH(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [20:0] act;
  assign act = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                bus.PCSource, bus.InvalidOp, bus.State};

  int n_pass = 0;
  int n_total = 0;
  int m_state = 0;      // model's current step
  int route[$];         // remaining steps of the current instruction
  logic [20:0] log_q[$];
  logic [5:0] cur_op;

  task automatic check(input string name, input int a, input int e);
    n_total++;
    if (a == e) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, a, e, $time);
  endtask

  // Controls each step must drive, taken straight from the per-step rules.
  function automatic logic [20:0] exp_out(input int st, input logic mr, input logic [5:0] op);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, inv;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, inv} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      1:  begin asb = 2'b11; inv = !(op inside {OpR, OpLw, OpSw, OpBeq, OpJ, OpAddi}); end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      9:  begin pcw = 1; pcs = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, inv, 4'(st)};
  endfunction

  // Advance the model one clock: each opcode owns a fixed route of steps after DECODE;
  // the memory steps repeat while MemReady is low.
  task automatic model_step(input logic mr, input logic [5:0] op);
    if (m_state == 0) begin
      route.delete();
      m_state = mr ? 1 : 0;
    end else if ((m_state == 3 || m_state == 5) && !mr) begin
      m_state = m_state;
    end else begin
      if (m_state == 1) begin
        case (op)
          OpLw:    route = '{2, 3, 4};
          OpSw:    route = '{2, 5};
          OpR:     route = '{6, 7};
          OpBeq:   route = '{8};
          OpJ:     route = '{9};
          OpAddi:  route = '{10, 11};
          default: route.delete();
        endcase
      end
      m_state = (route.size() == 0) ? 0 : route.pop_front();
    end
  endtask

  // One clock: drive at negedge, compare the whole control vector, then step the model.
  task automatic cycle(input logic mr, input logic [5:0] op);
    logic [20:0] e;
    @(negedge clock);
    bus.MemReady = mr;
    bus.Opcode   = op;
    #1;
    e = exp_out(m_state, mr, op);
    check($sformatf("model step %0d", m_state), int'(act), int'(e));
    log_q.push_back(act);
    @(posedge clock);
    model_step(mr, op);
  endtask

  function automatic int st_at(input int i);
    return int'(log_q[i][3:0]);
  endfunction

  function automatic int bit_at(input int i, input int b);
    return int'(log_q[i][b]);
  endfunction

  function automatic int count_bit(input int b);
    int c = 0;
    foreach (log_q[i]) c += int'(log_q[i][b]);
    return c;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq_lw[6] = '{0, 1, 2, 3, 4, 0};
    int seq_r[5]  = '{0, 1, 6, 7, 0};
    int seq_bq[4] = '{0, 1, 8, 0};
    int seq_j[4]  = '{0, 1, 9, 0};

    reset_n = 1'b0;
    bus.MemReady = 1'b0;
    bus.Opcode = 6'h00;
    #22;
    // Reset state: only MemRead and ALUSrcB=01 are high.
    check("reset vector", int'(act), 21'h020200);
    @(negedge clock);
    reset_n = 1'b1;

    // lw: 0,1,2,3,4,0 with MemtoReg/RegWrite only in step 4.
    log_q.delete();
    repeat (5) cycle(1'b1, OpLw);
    cycle(1'b0, OpLw);
    foreach (seq_lw[i]) check($sformatf("lw state[%0d]", i), st_at(i), seq_lw[i]);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("lw MemtoReg[%0d]", i), bit_at(i, BMemtoReg), (i == 4) ? 1 : 0);
      check($sformatf("lw RegWrite[%0d]", i), bit_at(i, BRegWrite), (i == 4) ? 1 : 0);
    end

    // R-type: 0,1,6,7,0.
    log_q.delete();
    repeat (4) cycle(1'b1, OpR);
    cycle(1'b0, OpR);
    foreach (seq_r[i]) check($sformatf("r state[%0d]", i), st_at(i), seq_r[i]);
    check("r ALUOp in 6", int'(log_q[2][8:7]), 2);
    check("r RegDst in 7", bit_at(3, BRegDst), 1);
    check("r MemtoReg in 7", bit_at(3, BMemtoReg), 0);
    check("r RegWrite in 7", bit_at(3, BRegWrite), 1);

    // sw with three stall cycles in MEMWRITE.
    log_q.delete();
    repeat (3) cycle(1'b1, OpSw);
    repeat (3) cycle(1'b0, OpSw);
    cycle(1'b1, OpSw);
    cycle(1'b0, OpSw);
    check("sw MemWrite count", count_bit(BMemWrite), 4);
    for (int i = 3; i < 7; i++) check($sformatf("sw MemWrite[%0d]", i), bit_at(i, BMemWrite), 1);
    check("sw RegWrite count", count_bit(BRegWrite), 0);
    check("sw end state", st_at(7), 0);

    // FETCH stall: IRWrite/PCWrite only in the ready cycle.
    log_q.delete();
    cycle(1'b0, OpR);
    cycle(1'b0, OpR);
    cycle(1'b1, OpR);
    cycle(1'b1, OpR);
    cycle(1'b1, OpR);
    cycle(1'b1, OpR);
    cycle(1'b0, OpR);
    check("stall IRWrite count", count_bit(BIrWrite), 1);
    check("stall IRWrite ready", bit_at(2, BIrWrite), 1);
    check("stall PCWrite ready", bit_at(2, BPcWrite), 1);
    check("stall PCWrite held", bit_at(1, BPcWrite), 0);
    check("stall decode next", st_at(3), 1);

    // Unsupported opcode then beq.
    log_q.delete();
    cycle(1'b1, 6'h3f);
    cycle(1'b0, 6'h3f);
    cycle(1'b0, 6'h3f);
    check("inv pulse", bit_at(1, BInvalid), 1);
    check("inv count", count_bit(BInvalid), 1);
    check("inv back to fetch", st_at(2), 0);
    log_q.delete();
    repeat (3) cycle(1'b1, OpBeq);
    cycle(1'b0, OpBeq);
    foreach (seq_bq[i]) check($sformatf("beq state[%0d]", i), st_at(i), seq_bq[i]);
    check("beq PCWriteCond", bit_at(2, BPcWriteCond), 1);
    check("beq PCSource", int'(log_q[2][6:5]), 1);

    // Reset asserted in MEMREAD aborts the lw with no writeback.
    repeat (3) cycle(1'b1, OpLw);
    @(negedge clock);
    bus.MemReady = 1'b0;
    #1;
    check("abort pre state", int'(bus.State), 3);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset state", int'(bus.State), 0);
    check("async reset RegWrite", int'(bus.RegWrite), 0);
    check("async reset MemWrite", int'(bus.MemWrite), 0);
    @(posedge clock);
    #1;
    check("reset held state", int'(bus.State), 0);
    check("reset held RegWrite", int'(bus.RegWrite), 0);
    m_state = 0;
    route.delete();
    @(negedge clock);
    reset_n = 1'b1;
    log_q.delete();
    repeat (3) cycle(1'b1, OpJ);
    cycle(1'b0, OpJ);
    foreach (seq_j[i]) check($sformatf("j state[%0d]", i), st_at(i), seq_j[i]);
    check("j PCSource", int'(log_q[2][6:5]), 2);
    check("j no RegWrite", count_bit(BRegWrite), 0);

    // Random traffic: opcode held only where it is sampled, garbage elsewhere.
    cur_op = OpR;
    for (int n = 0; n < 800; n++) begin
      logic mr;
      logic [5:0] op;
      if (m_state == 0) begin
        case ($urandom_range(0, 6))
          0: cur_op = OpR;
          1: cur_op = OpLw;
          2: cur_op = OpSw;
          3: cur_op = OpBeq;
          4: cur_op = OpJ;
          5: cur_op = OpAddi;
          default: cur_op = 6'($urandom);
        endcase
      end
      op = (m_state == 1 || m_state == 2) ? cur_op : 6'($urandom);
      mr = ($urandom_range(0, 3) != 0);
      cycle(mr, op);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
